seq_pattern_detector: RTL and testbench

//  Programmable input-sequence detector; runtime-loaded successor to the fixed 13-state FSM.

---
 rtl/seq_det_pkg.sv | 24 ++
 rtl/seq_step_table.sv | 48 ++++
 rtl/seq_pattern_detector.sv | 176 +++++++++++++++++
 tb/tb_seq_pattern_detector.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and match helper for the programmable sequence detector.
// The step-entry vector width is fixed here at SEQ_IN_W.
package seq_det_pkg;

  localparam int unsigned SEQ_IN_W = 4;

  typedef struct packed {
    logic [SEQ_IN_W-1:0] care;
    logic [SEQ_IN_W-1:0] val;
    logic                hold;
  } step_entry_t;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    SEARCH   = 2'd1,
    TRACK    = 2'd2
  } state_t;

  // Only the bits selected by care must equal val.
  function automatic logic match(input step_entry_t e, input logic [SEQ_IN_W-1:0] v);
    return ((v ^ e.val) & e.care) == '0;
  endfunction

endpackage

// File: rtl/seq_step_table.sv
// Step-table register file: one write port, two async read ports plus a fixed
// tap on entry 0 used for restart checks. Cleared by synchronous reset.
module seq_step_table
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_STEPS = 16,
  parameter int unsigned STEP_W    = $clog2(MAX_STEPS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [STEP_W-1:0] waddr,
  input  step_entry_t       wdata,
  input  logic [STEP_W-1:0] raddr_a,
  output step_entry_t       rdata_a,
  input  logic [STEP_W-1:0] raddr_b,
  output step_entry_t       rdata_b,
  output step_entry_t       head
);

  localparam int unsigned IDX_W = $clog2(MAX_STEPS);

  step_entry_t mem_q [MAX_STEPS];
  step_entry_t mem_d [MAX_STEPS];

  always_comb begin
    mem_d = mem_q;
    if (we && (waddr < STEP_W'(MAX_STEPS))) begin
      mem_d[IDX_W'(waddr)] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(MAX_STEPS); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Out-of-range addresses read as an all-zero entry.
  assign rdata_a = (raddr_a < STEP_W'(MAX_STEPS)) ? mem_q[IDX_W'(raddr_a)] : '0;
  assign rdata_b = (raddr_b < STEP_W'(MAX_STEPS)) ? mem_q[IDX_W'(raddr_b)] : '0;
  assign head    = mem_q[0];

endmodule

// File: rtl/seq_pattern_detector.sv
// Programmable input-sequence detector: FSM, step counter and length register.
// Define SEQDET_TIMEOUT_EN to abort a partial sequence after TIMEOUT idle TRACK cycles.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int unsigned IN_W      = SEQ_IN_W,
  parameter int unsigned MAX_STEPS = 16,
  parameter int unsigned STEP_W    = $clog2(MAX_STEPS + 1),
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              in_valid,
  input  logic [IN_W-1:0]   in_vec,
  input  logic              cfg_we,
  input  logic [STEP_W-1:0] cfg_addr,
  input  logic [IN_W-1:0]   cfg_care,
  input  logic [IN_W-1:0]   cfg_val,
  input  logic              cfg_hold,
  output logic [STEP_W-1:0] step,
  output logic              matched,
  output logic              fallback,
  output logic              cfg_err
);

  localparam int unsigned LEN_SRC_W = (IN_W > STEP_W) ? IN_W : STEP_W;

  state_t            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [STEP_W-1:0] len_q, len_d;
  logic              matched_q, matched_d;
  logic              fallback_q, fallback_d;
  logic              cfg_err_q, cfg_err_d;

  logic              active, track, tmo_hit, tmo_clr;
  logic              tbl_we;
  logic [STEP_W-1:0] rd_prev_addr;
  step_entry_t       ent_k, ent_p, ent_0, wr_entry;
  logic              m_k, m_p, m_0;
  logic [LEN_SRC_W-1:0] len_src;
  logic [STEP_W-1:0] len_wr;
  logic [STEP_W-1:0] step_inc;

  assign active       = enable && (len_q != '0);
  assign track        = (state_q == TRACK);
  assign rd_prev_addr = track ? STEP_W'(step_q - 1'b1) : '0;
  assign step_inc     = STEP_W'(step_q + 1'b1);
  assign tbl_we       = cfg_we && !enable && (cfg_addr < STEP_W'(MAX_STEPS));
  assign wr_entry     = '{care: SEQ_IN_W'(cfg_care), val: SEQ_IN_W'(cfg_val), hold: cfg_hold};

  // Length field rides in the low bits of cfg_val, zero-extended if narrower.
  assign len_src = LEN_SRC_W'(cfg_val);
  assign len_wr  = (len_src[STEP_W-1:0] > STEP_W'(MAX_STEPS)) ? STEP_W'(MAX_STEPS)
                                                             : len_src[STEP_W-1:0];

  seq_step_table #(
    .MAX_STEPS (MAX_STEPS),
    .STEP_W    (STEP_W)
  ) u_table (
    .clk     (clk),
    .reset   (reset),
    .we      (tbl_we),
    .waddr   (cfg_addr),
    .wdata   (wr_entry),
    .raddr_a (step_q),
    .rdata_a (ent_k),
    .raddr_b (rd_prev_addr),
    .rdata_b (ent_p),
    .head    (ent_0)
  );

  assign m_k = match(ent_k, SEQ_IN_W'(in_vec));
  assign m_p = match(ent_p, SEQ_IN_W'(in_vec));
  assign m_0 = match(ent_0, SEQ_IN_W'(in_vec));

  // Next-state: config handling, then step decisions in priority order.
  always_comb begin
    step_d     = step_q;
    len_d      = len_q;
    matched_d  = 1'b0;
    fallback_d = 1'b0;
    cfg_err_d  = cfg_we && enable;
    tmo_clr    = 1'b0;

    if (cfg_we && !enable && (cfg_addr == STEP_W'(MAX_STEPS))) begin
      len_d = len_wr;
    end

    if (!active) begin
      step_d = '0;
    end else if (tmo_hit) begin
      step_d     = '0;
      fallback_d = 1'b1;
    end else if (in_valid) begin
      if (m_k) begin
        tmo_clr = 1'b1;
        if (step_inc == len_q) begin
          matched_d = 1'b1;
          step_d    = '0;
        end else begin
          step_d = step_inc;
        end
      end else if (track && ent_p.hold && m_p) begin
        step_d = step_q;
      end else if (track) begin
        fallback_d = 1'b1;
        tmo_clr    = 1'b1;
        step_d     = m_0 ? STEP_W'(1) : '0;
      end
    end

    if (!active) begin
      state_d = DISABLED;
    end else if (step_d == '0) begin
      state_d = SEARCH;
    end else begin
      state_d = TRACK;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= DISABLED;
      step_q     <= '0;
      len_q      <= '0;
      matched_q  <= 1'b0;
      fallback_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      len_q      <= len_d;
      matched_q  <= matched_d;
      fallback_q <= fallback_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

`ifdef SEQDET_TIMEOUT_EN
  localparam int unsigned TMO_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Fires on the TRACK clock that would bring the count up to TIMEOUT.
  assign tmo_hit = active && track && (TMO_W'(tmo_q + 1'b1) == TMO_W'(TIMEOUT));

  always_comb begin
    tmo_d = tmo_q;
    if (!active || tmo_hit || tmo_clr || !track) begin
      tmo_d = '0;
    end else begin
      tmo_d = TMO_W'(tmo_q + 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  logic unused_tmo;

  assign tmo_hit    = 1'b0;
  assign unused_tmo = tmo_clr ^ 1'(TIMEOUT % 2);
`endif

  assign step     = step_q;
  assign matched  = matched_q;
  assign fallback = fallback_q;
  assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed self-checking bench for seq_pattern_detector (IN_W=4, MAX_STEPS=16).
module tb_seq_pattern_detector;

  localparam int unsigned IN_W   = 4;
  localparam int unsigned STEP_W = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic              in_valid;
  logic [IN_W-1:0]   in_vec;
  logic              cfg_we;
  logic [STEP_W-1:0] cfg_addr;
  logic [IN_W-1:0]   cfg_care;
  logic [IN_W-1:0]   cfg_val;
  logic              cfg_hold;
  logic [STEP_W-1:0] step;
  logic              matched;
  logic              fallback;
  logic              cfg_err;

  int vectors = 0;
  int miscompares = 0;

  seq_pattern_detector #(
    .IN_W      (IN_W),
    .MAX_STEPS (16),
    .TIMEOUT   (10)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .in_valid (in_valid),
    .in_vec   (in_vec),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_care (cfg_care),
    .cfg_val  (cfg_val),
    .cfg_hold (cfg_hold),
    .step     (step),
    .matched  (matched),
    .fallback (fallback),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input int exp_step, input int exp_m, input int exp_f);
    check({tag, "/step"},     32'(step),     32'(exp_step));
    check({tag, "/matched"},  32'(matched),  32'(exp_m));
    check({tag, "/fallback"}, 32'(fallback), 32'(exp_f));
  endtask

  task automatic cfg_write(input logic [STEP_W-1:0] addr, input logic [IN_W-1:0] care,
                           input logic [IN_W-1:0] val, input logic hold);
    cfg_we   = 1'b1;
    cfg_addr = addr;
    cfg_care = care;
    cfg_val  = val;
    cfg_hold = hold;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic sample(input logic [IN_W-1:0] v);
    in_valid = 1'b1;
    in_vec   = v;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic program_base();
    cfg_write(5'd0,  4'b0100, 4'b0100, 1'b0);
    cfg_write(5'd1,  4'b1001, 4'b1001, 1'b0);
    cfg_write(5'd2,  4'b0100, 4'b0000, 1'b0);
    cfg_write(5'd16, 4'b0000, 4'd3,    1'b0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; in_valid = 1'b0; in_vec = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_care = '0; cfg_val = '0; cfg_hold = 1'b0;
    tick();
    tick();
    chk3("reset", 0, 0, 0);
    check("reset/cfg_err", 32'(cfg_err), 32'd0);
    reset = 1'b0;

    program_base();

    // Basic three-step match
    enable = 1'b1;
    sample(4'b0100); chk3("t1a", 1, 0, 0);
    sample(4'b1001); chk3("t1b", 2, 0, 0);
    sample(4'b0000); chk3("t1c", 0, 1, 0);
    tick();          chk3("t1d", 0, 0, 0);

    // Mismatch aborts; restart re-checks entry 0
    sample(4'b0100); chk3("t2a", 1, 0, 0);
    sample(4'b0000); chk3("t2b", 0, 0, 1);
    sample(4'b0100); chk3("t2c", 1, 0, 0);
    sample(4'b0100); chk3("t2d", 1, 0, 1);
    tick();          chk3("t2e", 1, 0, 0);
    sample(4'b0000); chk3("t2f", 0, 0, 1);

    // Entry 1 hold: 1001 also satisfies entry 2, so the third sample completes
    enable = 1'b0;
    cfg_write(5'd1, 4'b1001, 4'b1001, 1'b1);
    enable = 1'b1;
    sample(4'b0100); chk3("t3a", 1, 0, 0);
    sample(4'b1001); chk3("t3b", 2, 0, 0);
    sample(4'b1001); chk3("t3c", 0, 1, 0);
    sample(4'b1001); chk3("t3d", 0, 0, 0);
    sample(4'b0000); chk3("t3e", 0, 0, 0);

    // Entry 0 hold: dwell on 0100 at step 1
    enable = 1'b0;
    cfg_write(5'd0, 4'b0100, 4'b0100, 1'b1);
    enable = 1'b1;
    sample(4'b0100); chk3("t3f", 1, 0, 0);
    sample(4'b0100); chk3("t3g", 1, 0, 0);
    sample(4'b0100); chk3("t3h", 1, 0, 0);
    sample(4'b1001); chk3("t3i", 2, 0, 0);
    sample(4'b0000); chk3("t3j", 0, 1, 0);

    // Write while enabled is dropped
    cfg_we = 1'b1; cfg_addr = 5'd0; cfg_care = 4'b1111; cfg_val = 4'b0000; cfg_hold = 1'b0;
    tick();
    cfg_we = 1'b0;
    check("t4/cfg_err", 32'(cfg_err), 32'd1);
    check("t4/step",    32'(step),    32'd0);
    tick();
    check("t4/cfg_err_clr", 32'(cfg_err), 32'd0);
    sample(4'b0100); chk3("t4a", 1, 0, 0);
    sample(4'b1001); chk3("t4b", 2, 0, 0);
    sample(4'b0000); chk3("t4c", 0, 1, 0);

    // Enable drop mid-sequence
    sample(4'b0100); chk3("dis_a", 1, 0, 0);
    enable = 1'b0;
    tick();          chk3("dis_b", 0, 0, 0);

    // Length 1: every entry-0 match pulses
    cfg_write(5'd16, 4'b0000, 4'd1, 1'b0);
    enable = 1'b1;
    sample(4'b0100); chk3("len1a", 0, 1, 0);
    sample(4'b0100); chk3("len1b", 0, 1, 0);
    sample(4'b0000); chk3("len1c", 0, 0, 0);

    // Length 0 stays disabled
    enable = 1'b0;
    cfg_write(5'd16, 4'b0000, 4'd0, 1'b0);
    enable = 1'b1;
    sample(4'b0100); chk3("len0", 0, 0, 0);

    // Reset mid-sequence clears step and table
    enable = 1'b0;
    cfg_write(5'd16, 4'b0000, 4'd3, 1'b0);
    enable = 1'b1;
    sample(4'b0100); chk3("t5a", 1, 0, 0);
    sample(4'b1001); chk3("t5b", 2, 0, 0);
    reset = 1'b1; in_valid = 1'b1; in_vec = 4'b0000;
    tick();          chk3("t5c", 0, 0, 0);
    reset = 1'b0; in_valid = 1'b0;
    sample(4'b0100); chk3("t5d", 0, 0, 0);
    enable = 1'b0;
    cfg_write(5'd16, 4'b0000, 4'd3, 1'b0);
    enable = 1'b1;
    sample(4'b0000); chk3("t5e", 1, 0, 0);
    sample(4'b0000); chk3("t5f", 2, 0, 0);
    sample(4'b0000); chk3("t5g", 0, 1, 0);

    // Idle dwell in TRACK
    enable = 1'b0;
    program_base();
    enable = 1'b1;
    sample(4'b0100); chk3("t6a", 1, 0, 0);
    for (int i = 1; i <= 12; i++) begin
      tick();
`ifdef SEQDET_TIMEOUT_EN
      chk3($sformatf("t6_%0d", i), (i < 10) ? 1 : 0, 0, (i == 10) ? 1 : 0);
`else
      chk3($sformatf("t6_%0d", i), 1, 0, 0);
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
